// File: rtl/adder_share_arb.sv
// Round-robin arbiter that shares one 3-bit adder between two valid/ready requesters.
// Optional grant statistics are enabled with the ADDER_SHARE_ARB_STATS_EN macro.

module adder_threebit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   output logic [2:0] s,
   output logic       cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

module adder_share_arb #(
   parameter bit START_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_a,
   input  logic [2:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_a,
   input  logic [2:0] req1_b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [2:0] resp_s,
   output logic       resp_cout,
   output logic       resp_id,
   output logic       busy
`ifdef ADDER_SHARE_ARB_STATS_EN
   ,
   output logic [7:0] gnt0_cnt,
   output logic [7:0] gnt1_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   state_t     state;
   logic       prio;
   logic [2:0] op_a;
   logic [2:0] op_b;
   logic       op_id;
   logic       grant_valid;
   logic       grant_id;
   logic [2:0] add_s;
   logic       add_cout;

   // A lone requester always wins; under contention the favoured one does.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = prio;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) && grant_valid && !grant_id && !rst;
   assign req1_ready = (state == IDLE) && grant_valid &&  grant_id && !rst;
   assign busy       = (state != IDLE);

   adder_threebit u_adder (
      .a    (op_a),
      .b    (op_b),
      .s    (add_s),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prio       <= START_PRIO;
         op_a       <= 3'd0;
         op_b       <= 3'd0;
         op_id      <= 1'b0;
         resp_valid <= 1'b0;
         resp_s     <= 3'd0;
         resp_cout  <= 1'b0;
         resp_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready) begin
                  op_a  <= req0_a;
                  op_b  <= req0_b;
                  op_id <= 1'b0;
                  state <= CALC;
               end else if (req1_ready) begin
                  op_a  <= req1_a;
                  op_b  <= req1_b;
                  op_id <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               resp_s     <= add_s;
               resp_cout  <= add_cout;
               resp_id    <= op_id;
               resp_valid <= 1'b1;
               prio       <= ~op_id;
               state      <= RESP;
            end
            RESP: begin
               // Result fields are left untouched so they keep their last value.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_SHARE_ARB_STATS_EN
   // Saturating per-requester grant counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0_cnt <= 8'd0;
         gnt1_cnt <= 8'd0;
      end else begin
         if (req0_ready && req0_valid && gnt0_cnt != 8'hff) gnt0_cnt <= gnt0_cnt + 8'd1;
         if (req1_ready && req1_valid && gnt1_cnt != 8'hff) gnt1_cnt <= gnt1_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.

module tb_adder_share_arb;

   localparam bit START = 1'b0;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready;
   logic [2:0] req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [2:0] req1_a, req1_b;
   logic       resp_valid, resp_ready;
   logic [2:0] resp_s;
   logic       resp_cout, resp_id, busy;
`ifdef ADDER_SHARE_ARB_STATS_EN
   logic [7:0] gnt0_cnt, gnt1_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 = free, 1 = computing, 2 = presenting result.
   int         m_phase = 0;
   logic       m_prio  = START;
   logic [2:0] m_a = 3'd0, m_b = 3'd0, m_s = 3'd0;
   logic       m_id = 1'b0, m_cout = 1'b0, m_rid = 1'b0;
   int         m_cnt0 = 0, m_cnt1 = 0;

   adder_share_arb #(.START_PRIO(START)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_s     (resp_s),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id),
      .busy       (busy)
`ifdef ADDER_SHARE_ARB_STATS_EN
      ,
      .gnt0_cnt   (gnt0_cnt),
      .gnt1_cnt   (gnt1_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected {req0_ready, req1_ready, resp_valid, busy, resp_s, resp_cout, resp_id}.
   function automatic logic [8:0] model_out();
      logic g0, g1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst && m_phase == 0) begin
         if (req0_valid && (!req1_valid || m_prio == 1'b0)) g0 = 1'b1;
         else if (req1_valid) g1 = 1'b1;
      end
      return {g0, g1, (m_phase == 2), (m_phase != 0), m_s, m_cout, m_rid};
   endfunction

   function automatic logic [8:0] observed();
      return {req0_ready, req1_ready, resp_valid, busy, resp_s, resp_cout, resp_id};
   endfunction

   // Update the model with the inputs present at the coming edge, then cross it.
   task automatic advance();
      logic [8:0] e;
      logic [3:0] sum;
      e = model_out();
      if (rst) begin
         m_phase = 0; m_prio = START; m_s = 3'd0; m_cout = 1'b0; m_rid = 1'b0;
         m_a = 3'd0; m_b = 3'd0; m_id = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      end else if (m_phase == 0) begin
         if (e[8]) begin
            m_a = req0_a; m_b = req0_b; m_id = 1'b0; m_phase = 1;
            if (m_cnt0 < 255) m_cnt0++;
         end else if (e[7]) begin
            m_a = req1_a; m_b = req1_b; m_id = 1'b1; m_phase = 1;
            if (m_cnt1 < 255) m_cnt1++;
         end
      end else if (m_phase == 1) begin
         sum    = {1'b0, m_a} + {1'b0, m_b};
         m_s    = sum[2:0];
         m_cout = sum[3];
         m_rid  = m_id;
         m_prio = ~m_id;
         m_phase = 2;
      end else if (resp_ready) begin
         m_phase = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] obs, exp;
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 3'd1; req0_b = 3'd1; req1_a = 3'd2; req1_b = 3'd2; resp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL reset_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (c < 2) begin
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
               errors++; $display("[TB] FAIL reset_ready_gate: got %b expected 00", {req0_ready, req1_ready});
            end
         end else begin
            checks++;
            if ({resp_valid, resp_s, resp_cout, busy} !== 6'd0) begin
               errors++; $display("[TB] FAIL reset_idle: got %b expected 000000", {resp_valid, resp_s, resp_cout, busy});
            end
         end
         advance();
      end
   endtask

   task automatic test_single_req0();
      logic [8:0] obs, exp;
      int seen;
      seen = -1;
      req0_valid = 1'b1; req0_a = 3'd4; req0_b = 3'd1; resp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL req0_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (c == 0) begin
            checks++;
            if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL req0_ready: got %b expected 1", req0_ready); end
         end
         if (resp_valid === 1'b1 && seen < 0) begin
            seen = c;
            checks++;
            if ({resp_s, resp_cout, resp_id} !== {3'd5, 1'b0, 1'b0}) begin
               errors++; $display("[TB] FAIL req0_result: got s=%0d c=%b id=%b expected s=5 c=0 id=0", resp_s, resp_cout, resp_id);
            end
         end
         advance();
         req0_valid = 1'b0;
      end
      checks++;
      if (seen != 2) begin errors++; $display("[TB] FAIL req0_latency: got %0d expected 2", seen); end
   endtask

   task automatic test_single_req1();
      logic [8:0] obs, exp;
      logic [4:0] want [2];
      int idx, hs;
      want[0] = {3'd0, 1'b1, 1'b1};
      want[1] = {3'd6, 1'b1, 1'b1};
      idx = 0; hs = 0;
      req1_valid = 1'b1; req1_a = 3'd4; req1_b = 3'd4; resp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL req1_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (resp_valid === 1'b1 && idx < 2) begin
            checks++;
            if ({resp_s, resp_cout, resp_id} !== want[idx]) begin
               errors++; $display("[TB] FAIL req1_result%0d: got %b expected %b", idx, {resp_s, resp_cout, resp_id}, want[idx]);
            end
            idx++;
         end
         if (req1_ready === 1'b1) hs++;
         advance();
         // Operands change while the first op is in flight; only the next handshake may see them.
         if (hs == 1) begin req1_a = 3'd7; req1_b = 3'd7; end
         if (hs >= 2) req1_valid = 1'b0;
      end
      checks++;
      if (idx != 2) begin errors++; $display("[TB] FAIL req1_count: got %0d expected 2", idx); end
   endtask

   task automatic test_contention();
      logic [8:0] obs, exp;
      logic next_gnt;
      int grants;
      next_gnt = 1'b0; grants = 0;
      req0_valid = 1'b1; req0_a = 3'd1; req0_b = 3'd2;
      req1_valid = 1'b1; req1_a = 3'd3; req1_b = 3'd3; resp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (c == 12) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL contend_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            checks++;
            if (req1_ready !== next_gnt) begin
               errors++; $display("[TB] FAIL contend_order g=%0d: got id %b expected %b", grants, req1_ready, next_gnt);
            end
            next_gnt = ~next_gnt;
            grants++;
         end
         if (resp_valid === 1'b1) begin
            checks++;
            if ({resp_s, resp_cout} !== (resp_id ? 4'b1100 : 4'b0110)) begin
               errors++; $display("[TB] FAIL contend_result: got s=%0d c=%b for id=%b", resp_s, resp_cout, resp_id);
            end
         end
         advance();
      end
      checks++;
      if (grants != 4) begin errors++; $display("[TB] FAIL contend_grants: got %0d expected 4", grants); end
   endtask

   task automatic test_backpressure();
      logic [8:0] obs, exp;
      req0_valid = 1'b1; req0_a = 3'd1; req0_b = 3'd1;
      req1_a = 3'd2; req1_b = 3'd5;
      for (int c = 0; c < 12; c++) begin
         resp_ready = (c >= 7);
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL bp_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (c >= 2 && c <= 7) begin
            checks++;
            if ({req1_ready, resp_valid, resp_s, resp_cout, resp_id} !== {1'b0, 1'b1, 3'd2, 1'b0, 1'b0}) begin
               errors++; $display("[TB] FAIL bp_hold c=%0d: got %b expected 0101000",
                                  c, {req1_ready, resp_valid, resp_s, resp_cout, resp_id});
            end
         end
         if (c == 8) begin
            checks++;
            if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept: got %b expected 1", req1_ready); end
         end
         advance();
         if (c == 0) req0_valid = 1'b0;
         if (c == 0) req1_valid = 1'b1;
         if (c == 8) req1_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid_op();
      logic [8:0] obs, exp;
      req0_valid = 1'b1; req0_a = 3'd2; req0_b = 3'd3; resp_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         rst = (c == 1);
         if (c == 5) begin req0_valid = 1'b1; req1_valid = 1'b1; end
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL rstmid_vec c=%0d: got %b expected %b", c, obs, exp); end
         if (c >= 2 && c <= 4) begin
            checks++;
            if ({resp_valid, busy, resp_s, resp_cout, resp_id} !== 7'd0) begin
               errors++; $display("[TB] FAIL rstmid_clear c=%0d: got %b expected 0000000",
                                  c, {resp_valid, busy, resp_s, resp_cout, resp_id});
            end
         end
         if (c == 5) begin
            checks++;
            if ({req0_ready, req1_ready} !== 2'b10) begin
               errors++; $display("[TB] FAIL rstmid_prio: got %b expected 10", {req0_ready, req1_ready});
            end
         end
         advance();
         if (c == 0 || c == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [8:0] obs, exp;
      for (int c = 0; c < 600; c++) begin
         rst        = ($urandom_range(0, 39) == 0);
         req0_valid = $urandom_range(0, 1) == 1;
         req1_valid = $urandom_range(0, 2) != 0;
         req0_a     = 3'($urandom_range(0, 7));
         req0_b     = 3'($urandom_range(0, 7));
         req1_a     = 3'($urandom_range(0, 7));
         req1_b     = 3'($urandom_range(0, 7));
         resp_ready = $urandom_range(0, 9) < 7;
         @(negedge clk);
         obs = observed(); exp = model_out();
         checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL random_vec c=%0d: got %b expected %b", c, obs, exp); end
         advance();
      end
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
`ifdef ADDER_SHARE_ARB_STATS_EN
      checks++;
      if ({gnt0_cnt, gnt1_cnt} !== {8'(m_cnt0), 8'(m_cnt1)}) begin
         errors++; $display("[TB] FAIL random_stats: got %0d/%0d expected %0d/%0d", gnt0_cnt, gnt1_cnt, m_cnt0, m_cnt1);
      end
`endif
   endtask

`ifdef ADDER_SHARE_ARB_STATS_EN
   task automatic test_stats();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      advance();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0_cnt, gnt1_cnt} !== 16'd0) begin
         errors++; $display("[TB] FAIL stats_clear: got %0d/%0d expected 0/0", gnt0_cnt, gnt1_cnt);
      end
      req0_valid = 1'b1; req0_a = 3'd3; req0_b = 3'd2;
      for (int c = 0; c < 900; c++) advance();
      req0_valid = 1'b0;
      for (int c = 0; c < 3; c++) advance();
      @(negedge clk);
      checks++;
      if ({gnt0_cnt, gnt1_cnt} !== {8'd255, 8'd0}) begin
         errors++; $display("[TB] FAIL stats_saturate: got %0d/%0d expected 255/0 (model %0d)", gnt0_cnt, gnt1_cnt, m_cnt0);
      end
      advance();
   endtask
`endif

   initial begin
      test_reset();
      test_single_req0();
      test_single_req1();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_random();
`ifdef ADDER_SHARE_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
